ipv4_ttl_checksum: RTL and testbench

AXI4-Stream pass-through stage for the router output-port-lookup pipeline. It verifies the IPv4 header checksum of every frame. In update mode it also decrements TTL and rewrites the header checksum incrementally (RFC 1624). Errors are flagged in TUSER and counted, and the last destination IP is exported. It sits after the lookup stage and before the output queues.

---
 rtl/ipv4_csum_pkg.sv | 31 +++
 rtl/fallthrough_small_fifo.sv | 60 ++++++
 rtl/ipv4_ttl_checksum.sv | 206 ++++++++++++++++++++
 tb/tb_ipv4_ttl_checksum.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipv4_csum_pkg.sv
// Shared types and constants for the IPv4 TTL / header-checksum stage.
// Byte offsets are relative to the start of the IPv4 header.
package ipv4_csum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        EMIT0,
        PASS
    } state_t;

    localparam logic [15:0] ETHERTYPE_IPV4     = 16'h0800;
    localparam int          IP_OFFSET_UNTAGGED = 14;
    localparam int          IP_OFFSET_VLAN     = 18;
    localparam logic [7:0]  IPV4_VER_IHL       = 8'h45;

    localparam int HDR_TTL   = 8;
    localparam int HDR_PROTO = 9;
    localparam int HDR_CSUM  = 10;
    localparam int HDR_WORDS = 10;

    // End-around carry fold of a 20-bit sum of 16-bit words down to 16 bits.
    function automatic logic [15:0] csum_fold(input logic [19:0] sum);
        logic [16:0] t1;
        logic [16:0] t2;
        t1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
        t2 = {1'b0, t1[15:0]} + {16'd0, t1[16]};
        return t2[15:0];
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: the head entry is visible on dout
// whenever empty is low; rd_en pops it.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int CW    = MAX_DEPTH_BITS + 1;
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
    localparam logic [CW-1:0] NEAR_LEVEL = CW'(DEPTH - 1);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_reg;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_reg;
    logic [CW-1:0]             count_reg;
    logic                      do_wr;
    logic                      do_rd;

    assign do_rd       = rd_en && (count_reg != '0);
    assign do_wr       = wr_en && (count_reg != FULL_LEVEL);
    assign dout        = mem[rd_ptr_reg];
    assign empty       = (count_reg == '0);
    assign nearly_full = (count_reg >= NEAR_LEVEL);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ipv4_ttl_checksum.sv
// AXI4-Stream stage that verifies the IPv4 header checksum, optionally decrements
// TTL with an incremental checksum rewrite, flags errors in TUSER and counts frames.
module ipv4_ttl_checksum
    import ipv4_csum_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_FIFO_DEPTH_BITS    = 2,
    parameter int C_IP_OFFSET          = 14,
    parameter int C_UPDATE_EN          = 1,
    parameter int C_ERR_BIT            = 32
) (
    input  logic                              AXI_ACLK,
    input  logic                              AXI_RESET,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic                              S_AXIS_TLAST,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                              M_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY,
    output logic                              M_AXIS_TLAST,
    output logic [31:0]                       good_count,
    output logic [31:0]                       bad_csum_count,
    output logic [31:0]                       ttl_expired_count,
    output logic [31:0]                       last_dst_ip
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int FW = DW + UW + SW + 1;

    localparam int ETYPE_BYTE = C_IP_OFFSET - 2;
    localparam int TTL_BYTE   = C_IP_OFFSET + HDR_TTL;
    localparam int PROTO_BYTE = C_IP_OFFSET + HDR_PROTO;
    localparam int CSUM_BYTE  = C_IP_OFFSET + HDR_CSUM;
    localparam bit OFFSET_OK  = (C_IP_OFFSET == IP_OFFSET_UNTAGGED) ||
                                (C_IP_OFFSET == IP_OFFSET_VLAN);

    logic [FW-1:0] fifo_din;
    logic [FW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic          fifo_nearly_full;
    logic          fifo_empty;

    logic [DW-1:0] head_data;
    logic [SW-1:0] head_strb;
    logic [UW-1:0] head_user;
    logic          head_last;

    state_t        state_reg;
    logic [DW-1:0] hold_data_reg;
    logic [SW-1:0] hold_strb_reg;
    logic [UW-1:0] hold_user_reg;
    logic          hold_last_reg;
    logic          is_ip_reg;
    logic          csum_bad_reg;
    logic          ttl_exp_reg;
    logic [31:0]   dst_ip_reg;

    logic [15:0]   hdr_word [HDR_WORDS];
    logic [19:0]   csum_sum;
    logic          csum_ok;
    logic          is_ip;
    logic [7:0]    ttl;
    logic [7:0]    proto;
    logic [7:0]    ttl_dec;
    logic          ttl_expired;
    logic [15:0]   m_old;
    logic [15:0]   m_new;
    logic [15:0]   hc_new;

    assign fifo_din = {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
    assign {head_last, head_user, head_strb, head_data} = fifo_dout;
    assign S_AXIS_TREADY = !fifo_nearly_full;

    fallthrough_small_fifo #(
        .WIDTH          (FW),
        .MAX_DEPTH_BITS (C_FIFO_DEPTH_BITS)
    ) u_in_fifo (
        .clk         (AXI_ACLK),
        .reset       (AXI_RESET),
        .din         (fifo_din),
        .wr_en       (S_AXIS_TVALID && S_AXIS_TREADY),
        .rd_en       (fifo_rd_en),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    // Header words live in the held beat 0 or, past byte 31, in the peeked beat 1.
    genvar gi;
    generate
        for (gi = 0; gi < HDR_WORDS; gi++) begin : g_hdr_word
            localparam int P = C_IP_OFFSET + 2 * gi;
            if (P < SW) begin : g_beat0
                assign hdr_word[gi] = hold_data_reg[DW-1-8*P -: 16];
            end else begin : g_beat1
                assign hdr_word[gi] = head_data[DW-1-8*(P-SW) -: 16];
            end
        end
    endgenerate

    always_comb begin
        csum_sum = '0;
        for (int i = 0; i < HDR_WORDS; i++) begin
            csum_sum = csum_sum + {4'd0, hdr_word[i]};
        end
        csum_ok     = (csum_fold(csum_sum) == 16'hFFFF);
        is_ip       = OFFSET_OK &&
                      (hold_data_reg[DW-1-8*ETYPE_BYTE -: 16] == ETHERTYPE_IPV4) &&
                      (hold_data_reg[DW-1-8*C_IP_OFFSET -: 8] == IPV4_VER_IHL);
        ttl         = hold_data_reg[DW-1-8*TTL_BYTE -: 8];
        proto       = hold_data_reg[DW-1-8*PROTO_BYTE -: 8];
        ttl_dec     = ttl - 8'd1;
        ttl_expired = (ttl <= 8'd1);
        m_old       = {ttl, proto};
        m_new       = {ttl_dec, proto};
        hc_new      = ~csum_fold({4'd0, ~hdr_word[HDR_CSUM/2]} + {4'd0, ~m_old} + {4'd0, m_new});
    end

    assign fifo_rd_en = !fifo_empty &&
                        ((state_reg == IDLE) || ((state_reg == PASS) && M_AXIS_TREADY));

    assign M_AXIS_TVALID = (state_reg == EMIT0) || ((state_reg == PASS) && !fifo_empty);
    assign M_AXIS_TDATA  = (state_reg == EMIT0) ? hold_data_reg : head_data;
    assign M_AXIS_TSTRB  = (state_reg == EMIT0) ? hold_strb_reg : head_strb;
    assign M_AXIS_TUSER  = (state_reg == EMIT0) ? hold_user_reg : head_user;
    assign M_AXIS_TLAST  = (state_reg == EMIT0) ? hold_last_reg : head_last;

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state_reg         <= IDLE;
            hold_data_reg     <= '0;
            hold_strb_reg     <= '0;
            hold_user_reg     <= '0;
            hold_last_reg     <= 1'b0;
            is_ip_reg         <= 1'b0;
            csum_bad_reg      <= 1'b0;
            ttl_exp_reg       <= 1'b0;
            dst_ip_reg        <= '0;
            good_count        <= '0;
            bad_csum_count    <= '0;
            ttl_expired_count <= '0;
            last_dst_ip       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        hold_data_reg <= head_data;
                        hold_strb_reg <= head_strb;
                        hold_user_reg <= head_user;
                        hold_last_reg <= head_last;
                        is_ip_reg     <= 1'b0;
                        csum_bad_reg  <= 1'b0;
                        ttl_exp_reg   <= 1'b0;
                        state_reg     <= head_last ? EMIT0 : HOLD;
                    end
                end
                HOLD: begin
                    if (!fifo_empty) begin
                        is_ip_reg    <= is_ip;
                        csum_bad_reg <= is_ip && !csum_ok;
                        ttl_exp_reg  <= is_ip && csum_ok && ttl_expired;
                        dst_ip_reg   <= {hdr_word[8], hdr_word[9]};
                        if (is_ip && (!csum_ok || ttl_expired)) begin
                            hold_user_reg[C_ERR_BIT] <= 1'b1;
                        end else if (is_ip && (C_UPDATE_EN != 0)) begin
                            hold_data_reg[DW-1-8*TTL_BYTE -: 8]   <= ttl_dec;
                            hold_data_reg[DW-1-8*CSUM_BYTE -: 16] <= hc_new;
                        end
                        state_reg <= EMIT0;
                    end
                end
                EMIT0: begin
                    if (M_AXIS_TREADY) begin
                        if (is_ip_reg) begin
                            last_dst_ip <= dst_ip_reg;
                            if (csum_bad_reg) begin
                                bad_csum_count <= bad_csum_count + 32'd1;
                            end else if (ttl_exp_reg) begin
                                ttl_expired_count <= ttl_expired_count + 32'd1;
                            end else begin
                                good_count <= good_count + 32'd1;
                            end
                        end
                        state_reg <= hold_last_reg ? IDLE : PASS;
                    end
                end
                PASS: begin
                    if (!fifo_empty && M_AXIS_TREADY && head_last) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipv4_ttl_checksum.sv
// Directed bench for ipv4_ttl_checksum: queue-driven source and sink with
// hand-computed expected frames and counter values.
module tb_ipv4_ttl_checksum;

    logic         AXI_ACLK;
    logic         AXI_RESET;
    logic [255:0] S_AXIS_TDATA;
    logic [31:0]  S_AXIS_TSTRB;
    logic [127:0] S_AXIS_TUSER;
    logic         S_AXIS_TVALID;
    logic         S_AXIS_TREADY;
    logic         S_AXIS_TLAST;
    logic [255:0] M_AXIS_TDATA;
    logic [31:0]  M_AXIS_TSTRB;
    logic [127:0] M_AXIS_TUSER;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TREADY;
    logic         M_AXIS_TLAST;
    logic [31:0]  good_count;
    logic [31:0]  bad_csum_count;
    logic [31:0]  ttl_expired_count;
    logic [31:0]  last_dst_ip;

    ipv4_ttl_checksum dut (
        .AXI_ACLK          (AXI_ACLK),
        .AXI_RESET         (AXI_RESET),
        .S_AXIS_TDATA      (S_AXIS_TDATA),
        .S_AXIS_TSTRB      (S_AXIS_TSTRB),
        .S_AXIS_TUSER      (S_AXIS_TUSER),
        .S_AXIS_TVALID     (S_AXIS_TVALID),
        .S_AXIS_TREADY     (S_AXIS_TREADY),
        .S_AXIS_TLAST      (S_AXIS_TLAST),
        .M_AXIS_TDATA      (M_AXIS_TDATA),
        .M_AXIS_TSTRB      (M_AXIS_TSTRB),
        .M_AXIS_TUSER      (M_AXIS_TUSER),
        .M_AXIS_TVALID     (M_AXIS_TVALID),
        .M_AXIS_TREADY     (M_AXIS_TREADY),
        .M_AXIS_TLAST      (M_AXIS_TLAST),
        .good_count        (good_count),
        .bad_csum_count    (bad_csum_count),
        .ttl_expired_count (ttl_expired_count),
        .last_dst_ip       (last_dst_ip)
    );

    typedef struct packed {
        logic [255:0] data;
        logic [127:0] user;
        logic         last;
    } beat_t;

    beat_t      in_q[$];
    beat_t      exp_q[$];
    logic [7:0] fb [128];
    int         checks = 0;
    int         errors = 0;
    int         out_beats = 0;
    logic       in_fire = 1'b0;
    logic       rand_ready = 1'b0;
    logic       stall_out = 1'b0;

    initial begin
        AXI_ACLK = 1'b0;
        forever #5 AXI_ACLK = ~AXI_ACLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", tag, actual, expected);
        end
    endtask

    task automatic fill_payload(input logic [7:0] seed);
        for (int i = 0; i < 128; i++) fb[i] = seed + 8'(i * 3);
    endtask

    task automatic put_word(input int pos, input logic [15:0] w);
        fb[pos]     = w[15:8];
        fb[pos + 1] = w[7:0];
    endtask

    // Untagged frame: ethertype at byte 12, IPv4 header at bytes 14..33.
    task automatic put_ipv4(input logic [7:0] ttl, input logic [15:0] hc, input logic [15:0] dst_lo);
        put_word(12, 16'h0800);
        put_word(14, 16'h4500);
        put_word(16, 16'h0054);
        put_word(18, 16'h0000);
        put_word(20, 16'h4000);
        put_word(22, {ttl, 8'h01});
        put_word(24, hc);
        put_word(26, 16'hC0A8);
        put_word(28, 16'h0001);
        put_word(30, 16'hC0A8);
        put_word(32, dst_lo);
    endtask

    task automatic build_beat(input int k, input int nbeats, output beat_t b);
        b.data = '0;
        for (int i = 0; i < 32; i++) b.data[255 - 8*i -: 8] = fb[32*k + i];
        b.user = {96'd0, 32'h0000_1000 | 32'(k)};
        b.last = (k == nbeats - 1);
    endtask

    task automatic push_in(input int nbeats);
        beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            build_beat(k, nbeats, b);
            in_q.push_back(b);
        end
    endtask

    task automatic push_exp(input int nbeats, input logic err);
        beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            build_beat(k, nbeats, b);
            if (k == 0) b.user[32] = err;
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            @(negedge AXI_ACLK);
            n++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        repeat (3) @(negedge AXI_ACLK);
    endtask

    task automatic check_counters(input string tag, input int good, input int bad,
                                  input int expired, input logic [31:0] dst);
        check({tag, "_good"}, good_count, good);
        check({tag, "_bad"}, bad_csum_count, bad);
        check({tag, "_ttl"}, ttl_expired_count, expired);
        check({tag, "_dst"}, last_dst_ip, dst);
        $display("%s: good=%0d bad=%0d ttl=%0d dst=%08h", tag, good_count, bad_csum_count,
                 ttl_expired_count, last_dst_ip);
    endtask

    // Source: decide the handshake after the negedge so the posedge sees settled values.
    initial begin
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TSTRB  = 32'hFFFF_FFFF;
        S_AXIS_TUSER  = '0;
        S_AXIS_TLAST  = 1'b0;
        forever begin
            @(negedge AXI_ACLK);
            if (in_fire && in_q.size() > 0) void'(in_q.pop_front());
            if (in_q.size() > 0 && !AXI_RESET) begin
                S_AXIS_TVALID = 1'b1;
                S_AXIS_TDATA  = in_q[0].data;
                S_AXIS_TUSER  = in_q[0].user;
                S_AXIS_TLAST  = in_q[0].last;
            end else begin
                S_AXIS_TVALID = 1'b0;
            end
            #1;
            in_fire = S_AXIS_TVALID && S_AXIS_TREADY;
        end
    end

    // Sink: compares accepted beats against the expected queue and checks stalls.
    initial begin
        beat_t        e;
        logic         prev_stall;
        logic [255:0] prev_data;
        logic [128:0] prev_ul;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_ul    = '0;
        M_AXIS_TREADY = 1'b0;
        forever begin
            @(negedge AXI_ACLK);
            if (stall_out) M_AXIS_TREADY = 1'b0;
            else if (rand_ready) M_AXIS_TREADY = 1'($urandom_range(0, 1));
            else M_AXIS_TREADY = 1'b1;
            #1;
            if (AXI_RESET) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", M_AXIS_TVALID, 1);
                    check("stall_data", M_AXIS_TDATA, prev_data);
                    check("stall_user_last", {M_AXIS_TUSER, M_AXIS_TLAST}, prev_ul);
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", M_AXIS_TVALID, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", M_AXIS_TDATA, e.data);
                        check("beat_user", M_AXIS_TUSER, e.user);
                        check("beat_last", M_AXIS_TLAST, e.last);
                        check("beat_strb", M_AXIS_TSTRB, 32'hFFFF_FFFF);
                    end
                    $display("out beat %0d: last=%0b user=%0h data[255:128]=%032h", out_beats,
                             M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TDATA[255:128]);
                    out_beats++;
                end
                prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
                prev_data  = M_AXIS_TDATA;
                prev_ul    = {M_AXIS_TUSER, M_AXIS_TLAST};
            end
        end
    end

    initial begin
        int base;
        int n;
        AXI_RESET = 1'b1;
        repeat (5) @(negedge AXI_ACLK);
        AXI_RESET = 1'b0;
        repeat (2) @(negedge AXI_ACLK);
        check("reset_m_tvalid", M_AXIS_TVALID, 0);
        check("reset_s_tready", S_AXIS_TREADY, 1);
        check_counters("reset", 0, 0, 0, 32'h0);

        // Good header: TTL 0x40 -> 0x3F, checksum 0xB1E6 -> 0xB2E6.
        fill_payload(8'h10);
        put_ipv4(8'h40, 16'hB1E6, 16'h0771);
        push_in(2);
        fb[22] = 8'h3F;
        put_word(24, 16'hB2E6);
        push_exp(2, 1'b0);
        wait_drain("update");
        check_counters("update", 1, 0, 0, 32'hC0A8_0771);

        // Corrupted checksum: data unchanged, error flagged.
        fill_payload(8'h20);
        put_ipv4(8'h40, 16'h0000, 16'h0771);
        push_in(3);
        push_exp(3, 1'b1);
        wait_drain("bad_csum");
        check_counters("bad_csum", 1, 1, 0, 32'hC0A8_0771);

        // TTL 1 with a valid checksum (0xF0E6).
        fill_payload(8'h30);
        put_ipv4(8'h01, 16'hF0E6, 16'h0771);
        push_in(2);
        push_exp(2, 1'b1);
        wait_drain("ttl_exp");
        check_counters("ttl_exp", 1, 1, 1, 32'hC0A8_0771);

        // ARP frame and a single-beat IPv4 frame pass through untouched.
        fill_payload(8'h40);
        put_ipv4(8'h40, 16'hB1E5, 16'h0772);
        put_word(12, 16'h0806);
        push_in(3);
        push_exp(3, 1'b0);
        fill_payload(8'h50);
        put_ipv4(8'h40, 16'hB1E5, 16'h0772);
        push_in(1);
        push_exp(1, 1'b0);
        wait_drain("non_ip");
        check_counters("non_ip", 1, 1, 1, 32'hC0A8_0771);

        // 20 back-to-back 4-beat frames with random backpressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            fill_payload(8'(f * 11 + 3));
            put_ipv4(8'h40, 16'hB1E6, 16'h0771);
            push_in(4);
            fb[22] = 8'h3F;
            put_word(24, 16'hB2E6);
            push_exp(4, 1'b0);
        end
        wait_drain("burst");
        rand_ready = 1'b0;
        check_counters("burst", 21, 1, 1, 32'hC0A8_0771);

        // Reset in the middle of frame 1's PASS phase.
        fill_payload(8'h60);
        put_ipv4(8'h40, 16'hB1E6, 16'h0771);
        push_in(4);
        fb[22] = 8'h3F;
        put_word(24, 16'hB2E6);
        push_exp(4, 1'b0);
        base = out_beats;
        n = 0;
        while (out_beats < base + 2 && n < 500) begin
            @(negedge AXI_ACLK);
            n++;
        end
        check("rst_reach_pass", out_beats >= base + 2, 1);
        stall_out = 1'b1;
        repeat (2) @(negedge AXI_ACLK);
        AXI_RESET = 1'b1;
        in_q.delete();
        exp_q.delete();
        repeat (3) @(negedge AXI_ACLK);
        check("midrst_m_tvalid", M_AXIS_TVALID, 0);
        check_counters("midrst", 0, 0, 0, 32'h0);
        AXI_RESET = 1'b0;
        stall_out = 1'b0;
        repeat (2) @(negedge AXI_ACLK);

        // Frame 2 after reset: dst 192.168.7.114, checksum 0xB1E5 -> 0xB2E5.
        fill_payload(8'h70);
        put_ipv4(8'h40, 16'hB1E5, 16'h0772);
        push_in(3);
        fb[22] = 8'h3F;
        put_word(24, 16'hB2E5);
        push_exp(3, 1'b0);
        wait_drain("post_rst");
        check_counters("post_rst", 1, 0, 0, 32'hC0A8_0772);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
